// File: rtl/argmax_pkg.sv
// Shared types and constants for the argmax scan engine.
package argmax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CAPTURE,
        ST_SCAN,
        ST_WRITE,
        ST_DONE
    } argmax_state_t;

    // READ, CAPTURE and WRITE wrap the WEIGHT_COLS-1 scan cycles of each row.
    localparam int ROW_OVERHEAD_CYCLES = 2;

    function automatic int row_cycles(input int cols);
        return cols + ROW_OVERHEAD_CYCLES;
    endfunction

endpackage

// File: rtl/argmax_scan_engine_cmp.sv
// Combinational greater-than used by the scan datapath; signedness chosen at elaboration.
module argmax_cmp #(
    parameter int W          = 16,
    parameter bit SIGNED_CMP = 1'b1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt
);

    if (SIGNED_CMP) begin : g_signed
        assign gt = $signed(a) > $signed(b);
    end else begin : g_unsigned
        assign gt = a > b;
    end

endmodule

// File: rtl/argmax_scan_engine.sv
// Row-by-row argmax over the output buffer: reads a row, scans one column per cycle,
// writes the winning index/value, and returns to idle once start is released.
module argmax_scan_engine
    import argmax_pkg::*;
#(
    parameter int FEATURE_ROWS      = 6,
    parameter int WEIGHT_COLS       = 3,
    parameter int DOT_PROD_WIDTH    = 16,
    parameter int MAX_ADDRESS_WIDTH = 2,
    parameter int ROW_ADDR_WIDTH    = 3,
    parameter bit SIGNED_CMP        = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  start,
    output logic                                  rd_en,
    output logic [ROW_ADDR_WIDTH-1:0]             rd_addr,
    input  logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] rd_data,
    output logic                                  wr_en,
    output logic [ROW_ADDR_WIDTH-1:0]             wr_addr,
    output logic [MAX_ADDRESS_WIDTH-1:0]          wr_idx,
    output logic [DOT_PROD_WIDTH-1:0]             wr_val,
    output logic                                  busy,
    output logic                                  done
);

    localparam int W = DOT_PROD_WIDTH;

    if (FEATURE_ROWS < 1 || WEIGHT_COLS < 1) begin : g_dim_chk
        $error("argmax_scan_engine: FEATURE_ROWS and WEIGHT_COLS must be >= 1");
    end
    if (MAX_ADDRESS_WIDTH < 1 || MAX_ADDRESS_WIDTH < $clog2(WEIGHT_COLS)) begin : g_idx_chk
        $error("argmax_scan_engine: MAX_ADDRESS_WIDTH too narrow for WEIGHT_COLS");
    end
    if (ROW_ADDR_WIDTH < 1 || ROW_ADDR_WIDTH < $clog2(FEATURE_ROWS)) begin : g_row_chk
        $error("argmax_scan_engine: ROW_ADDR_WIDTH too narrow for FEATURE_ROWS");
    end

    localparam logic [ROW_ADDR_WIDTH-1:0]    LAST_ROW  = ROW_ADDR_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [MAX_ADDRESS_WIDTH-1:0] LAST_COL  = MAX_ADDRESS_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [MAX_ADDRESS_WIDTH-1:0] SCAN_COL0 = MAX_ADDRESS_WIDTH'((WEIGHT_COLS > 1) ? 1 : 0);

    argmax_state_t                   state, next_state;
    logic [ROW_ADDR_WIDTH-1:0]       row;
    logic [MAX_ADDRESS_WIDTH-1:0]    col;
    logic [WEIGHT_COLS-1:0][W-1:0]   row_q;
    logic [W-1:0]                    best_val;
    logic [MAX_ADDRESS_WIDTH-1:0]    best_idx;
    logic [W-1:0]                    cand_val;
    logic                            cand_gt;
    logic [ROW_ADDR_WIDTH-1:0]       rd_addr_q, wr_addr_q;
    logic [MAX_ADDRESS_WIDTH-1:0]    wr_idx_q;
    logic [W-1:0]                    wr_val_q;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) next_state = ST_READ;
            end
            ST_READ: begin
                rd_en      = 1'b1;
                next_state = ST_CAPTURE;
            end
            ST_CAPTURE: next_state = (WEIGHT_COLS > 1) ? ST_SCAN : ST_WRITE;
            ST_SCAN:    if (col == LAST_COL) next_state = ST_WRITE;
            ST_WRITE: begin
                wr_en      = 1'b1;
                next_state = (row == LAST_ROW) ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        cand_val = '0;
        for (int c = 0; c < WEIGHT_COLS; c++)
            if (col == MAX_ADDRESS_WIDTH'(c)) cand_val = row_q[c];
    end

    argmax_cmp #(.W(W), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
        .a  (cand_val),
        .b  (best_val),
        .gt (cand_gt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row       <= '0;
            col       <= '0;
            row_q     <= '0;
            best_val  <= '0;
            best_idx  <= '0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_idx_q  <= '0;
            wr_val_q  <= '0;
        end else begin
            case (state)
                ST_READ: rd_addr_q <= row;
                ST_CAPTURE: begin
                    row_q    <= rd_data;
                    best_val <= rd_data[W-1:0];
                    best_idx <= '0;
                    col      <= SCAN_COL0;
                end
                ST_SCAN: begin
                    // Strict compare: ties keep the earlier (lower) column.
                    if (cand_gt) begin
                        best_val <= cand_val;
                        best_idx <= col;
                    end
                    if (col != LAST_COL) col <= col + 1'b1;
                end
                ST_WRITE: begin
                    wr_addr_q <= row;
                    wr_idx_q  <= best_idx;
                    wr_val_q  <= best_val;
                    if (row != LAST_ROW) row <= row + 1'b1;
                end
                ST_DONE: begin
                    if (!start) begin
                        row <= '0;
                        col <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Address/data buses show the live value under their strobe and hold it afterwards.
    assign rd_addr = rd_en ? row      : rd_addr_q;
    assign wr_addr = wr_en ? row      : wr_addr_q;
    assign wr_idx  = wr_en ? best_idx : wr_idx_q;
    assign wr_val  = wr_en ? best_val : wr_val_q;

endmodule

// File: tb/tb_argmax_scan_engine.sv
// Directed bench: 6x3 signed engine, 1x3 unsigned engine, 1x1 corner engine.
// Cycle numbering counts the edge that samples start as cycle 1.
module tb_argmax_scan_engine;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        start0, rd_en0, wr_en0, busy0, done0;
    logic [2:0]  rd_addr0, wr_addr0;
    logic [47:0] rd_data0;
    logic [1:0]  wr_idx0;
    logic [15:0] wr_val0;

    logic        start1, rd_en1, wr_en1, busy1, done1;
    logic [0:0]  rd_addr1, wr_addr1;
    logic [47:0] rd_data1;
    logic [1:0]  wr_idx1;
    logic [15:0] wr_val1;

    logic        start2, rd_en2, wr_en2, busy2, done2;
    logic [0:0]  rd_addr2, wr_addr2;
    logic [15:0] rd_data2;
    logic [0:0]  wr_idx2;
    logic [15:0] wr_val2;

    argmax_scan_engine #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .DOT_PROD_WIDTH(16),
        .MAX_ADDRESS_WIDTH(2), .ROW_ADDR_WIDTH(3), .SIGNED_CMP(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_idx(wr_idx0),
        .wr_val(wr_val0), .busy(busy0), .done(done0));

    argmax_scan_engine #(.FEATURE_ROWS(1), .WEIGHT_COLS(3), .DOT_PROD_WIDTH(16),
        .MAX_ADDRESS_WIDTH(2), .ROW_ADDR_WIDTH(1), .SIGNED_CMP(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_idx(wr_idx1),
        .wr_val(wr_val1), .busy(busy1), .done(done1));

    argmax_scan_engine #(.FEATURE_ROWS(1), .WEIGHT_COLS(1), .DOT_PROD_WIDTH(16),
        .MAX_ADDRESS_WIDTH(1), .ROW_ADDR_WIDTH(1), .SIGNED_CMP(1'b1)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .rd_en(rd_en2), .rd_addr(rd_addr2),
        .rd_data(rd_data2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_idx(wr_idx2),
        .wr_val(wr_val2), .busy(busy2), .done(done2));

    // Output buffer models: one-cycle read latency.
    logic [47:0] mem0 [8];
    logic [47:0] mem1;
    logic [15:0] mem2;
    always @(posedge clk) if (rd_en0) rd_data0 <= mem0[rd_addr0];
    always @(posedge clk) if (rd_en1) rd_data1 <= mem1;
    always @(posedge clk) if (rd_en2) rd_data2 <= mem2;

    typedef struct packed {
        logic [2:0]  a;
        logic [1:0]  i;
        logic [15:0] v;
    } wr_t;

    wr_t        wq0[$];
    logic [2:0] rq0[$];
    wr_t        wq1[$];
    wr_t        wq2[$];

    always @(negedge clk) begin
        if (wr_en0) wq0.push_back({wr_addr0, wr_idx0, wr_val0});
        if (rd_en0) rq0.push_back(rd_addr0);
        if (wr_en1) wq1.push_back({2'b00, wr_addr1, wr_idx1, wr_val1});
        if (wr_en2) wq2.push_back({2'b00, wr_addr2, 1'b0, wr_idx2, wr_val2});
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [47:0] mk(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    logic [1:0]  ei [6];
    logic [15:0] ev [6];

    // Starts a run on dut0 from IDLE and checks done timing plus all six row results.
    task automatic run0(input string tag);
        int base;
        int cyc;
        base   = wq0.size();
        start0 = 1'b1;
        cyc    = 0;
        do begin
            tick();
            cyc++;
        end while (!done0 && cyc < 200);
        chk({tag, " done_cycle"}, 32'(cyc), 32'd31);
        chk({tag, " wr_count"}, 32'(wq0.size() - base), 32'd6);
        for (int r = 0; r < 6; r++) begin
            if (base + r < wq0.size()) begin
                chk($sformatf("%s row%0d addr", tag, r), 32'(wq0[base+r].a), 32'(r));
                chk($sformatf("%s row%0d idx", tag, r), 32'(wq0[base+r].i), 32'(ei[r]));
                chk($sformatf("%s row%0d val", tag, r), 32'(wq0[base+r].v), 32'(ev[r]));
            end
        end
    endtask

    task automatic load_a();
        mem0[0] = mk(1, 5, 2);    ei[0] = 2'd1; ev[0] = 16'd5;
        mem0[1] = mk(9, 0, -3);   ei[1] = 2'd0; ev[1] = 16'd9;
        mem0[2] = mk(-1, -2, -3); ei[2] = 2'd0; ev[2] = 16'hFFFF;
        mem0[3] = mk(0, 0, 7);    ei[3] = 2'd2; ev[3] = 16'd7;
        mem0[4] = mk(4, 4, 1);    ei[4] = 2'd0; ev[4] = 16'd4;
        mem0[5] = mk(-8, -9, -7); ei[5] = 2'd2; ev[5] = 16'hFFF9;
    endtask

    task automatic load_b();
        mem0[0] = mk(3, 3, 3);       ei[0] = 2'd0; ev[0] = 16'd3;
        mem0[1] = mk(2, 7, 7);       ei[1] = 2'd1; ev[1] = 16'd7;
        mem0[2] = mk('hFFFF, 1, 0);  ei[2] = 2'd1; ev[2] = 16'd1;
        mem0[3] = mk(0, 0, 0);       ei[3] = 2'd0; ev[3] = 16'd0;
        mem0[4] = mk(-1, 5, -1);     ei[4] = 2'd1; ev[4] = 16'd5;
        mem0[5] = mk(10, 2, 10);     ei[5] = 2'd0; ev[5] = 16'd10;
    endtask

    initial begin
        int cyc;
        int rc;
        int wb;
        int rb;
        bit found;
        reset_n = 1'b0;
        start0  = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        mem0[6] = '0;
        mem0[7] = '0;
        mem1    = mk('hFFFF, 1, 0);
        mem2    = 16'hFFFB;
        load_a();
        repeat (2) tick();
        chk("reset strobes", 32'({rd_en0, wr_en0, busy0, done0}), 32'd0);
        chk("reset buses", 32'({rd_addr0, wr_addr0, wr_idx0, wr_val0}), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic run, start held through DONE
        run0("t1");
        rc = rq0.size();
        repeat (5) tick();
        chk("t4 done held", 32'(done0), 32'd1);
        chk("t4 no rd in done", 32'(rq0.size() - rc), 32'd0);
        chk("t4 wr buses hold", 32'({wr_addr0, wr_idx0, wr_val0}), 32'({3'd5, 2'd2, 16'hFFF9}));
        start0 = 1'b0;
        tick();
        chk("t4 back to idle", 32'({busy0, done0}), 32'd0);
        run0("t4 rerun");
        start0 = 1'b0;
        tick();

        // Ties and signed wrap row
        load_b();
        run0("t3");
        start0 = 1'b0;
        tick();

        // Mid-run reset during row 3 SCAN
        wb = wq0.size();
        start0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (rd_en0 && rd_addr0 == 3'd3) found = 1'b1;
        end
        chk("t5 reached row3", 32'(found), 32'd1);
        tick();
        tick();
        chk("t5 busy in scan", 32'(busy0), 32'd1);
        reset_n = 1'b0;
        start0  = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("t5 strobes after rst", 32'({rd_en0, wr_en0, busy0, done0}), 32'd0);
        chk("t5 buses after rst", 32'({rd_addr0, wr_addr0, wr_idx0, wr_val0}), 32'd0);
        chk("t5 rows written pre-rst", 32'(wq0.size() - wb), 32'd3);
        wb = wq0.size();
        rb = rq0.size();
        repeat (3) tick();
        chk("t5 quiet after rst", 32'((wq0.size() - wb) + (rq0.size() - rb)), 32'd0);
        run0("t5 restart");
        if (rq0.size() > rb) chk("t5 first rd_addr", 32'(rq0[rb]), 32'd0);
        else chk("t5 first rd_addr", 32'hFFFF_FFFF, 32'd0);
        start0 = 1'b0;
        tick();

        // Unsigned compare on {FFFF,1,0}
        start1 = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done1 && cyc < 100);
        chk("t2 unsigned done", 32'(done1), 32'd1);
        chk("t2 unsigned wr_count", 32'(wq1.size()), 32'd1);
        if (wq1.size() > 0) begin
            chk("t2 unsigned idx", 32'(wq1[0].i), 32'd0);
            chk("t2 unsigned val", 32'(wq1[0].v), 32'h0000_FFFF);
        end
        start1 = 1'b0;

        // 1x1 corner configuration
        start2 = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!done2 && cyc < 100);
        chk("t6 done_cycle", 32'(cyc), 32'd4);
        chk("t6 wr_count", 32'(wq2.size()), 32'd1);
        if (wq2.size() > 0) begin
            chk("t6 addr", 32'(wq2[0].a), 32'd0);
            chk("t6 idx", 32'(wq2[0].i), 32'd0);
            chk("t6 val", 32'(wq2[0].v), 32'h0000_FFFB);
        end
        start2 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
